// File: rtl/fetch_controller.sv
// fetch_controller: PC owner and instruction fetch sequencer.
// Issues one word read per cycle, buffers returns in a 2-entry queue and
// presents them to decode over valid/ready. Redirects squash in-flight reads.
// Optional: define FETCH_PERF_CNT_EN to add perf_fetched / perf_stall counters.
module fetch_controller #(
  parameter int                   WORD_SIZE  = 32,
  parameter int                   IMEM_DEPTH = 64,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 imem_req,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic [WORD_SIZE-1:0] imem_rdata,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [WORD_SIZE-1:0] instr_data,
  output logic [WORD_SIZE-1:0] instr_pc,
  output logic                 busy,
  output logic                 halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_stall
`endif
);

  localparam logic [WORD_SIZE-1:0] LAST_ADDR = WORD_SIZE'(IMEM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] pc;
  logic                 inflight;
  logic [WORD_SIZE-1:0] inflight_pc;
  logic [1:0]           count;
  logic [WORD_SIZE-1:0] head_data, head_pc, tail_data, tail_pc;

  logic       pop, push, issue, end_of_mem;
  logic [1:0] occ;

  // A redirect clears inflight in the same edge, so the squashed response
  // is simply never pushed.
  assign pop        = instr_valid & instr_ready;
  assign push       = inflight & ~redirect_valid;
  assign end_of_mem = pc > LAST_ADDR;
  assign occ        = 2'(count + {1'b0, inflight} - {1'b0, pop});
  assign issue      = (state == RUN) && !redirect_valid && !end_of_mem && (occ < 2'd2);

  assign imem_req    = issue;
  assign imem_addr   = pc;
  assign instr_valid = count != 2'd0;
  assign instr_data  = head_data;
  assign instr_pc    = head_pc;
  assign busy        = (state == RUN) || (state == DRAIN);
  assign halted      = state == HALT;

  // Next-state: redirect wins everywhere except IDLE, where only start leaves.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        if (redirect_valid)                   state_nxt = RUN;
        else if (end_of_mem)                  state_nxt = DRAIN;
        else if (issue && (pc == LAST_ADDR))  state_nxt = DRAIN;
      end
      DRAIN: begin
        if (redirect_valid)                      state_nxt = RUN;
        else if ((count == 2'd0) && !inflight)   state_nxt = HALT;
      end
      HALT:  if (redirect_valid) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // PC and in-flight read tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      if (redirect_valid) pc <= redirect_pc;
      else if (issue)     pc <= pc + 1'b1;
      inflight <= issue;
      if (issue) inflight_pc <= pc;
    end
  end

  // Two-entry queue: head feeds decode, tail catches a return while head waits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count     <= 2'd0;
      head_data <= '0;
      head_pc   <= '0;
      tail_data <= '0;
      tail_pc   <= '0;
    end else if (redirect_valid) begin
      count <= 2'd0;
    end else begin
      if (pop) begin
        if (count == 2'd2) begin
          head_data <= tail_data;
          head_pc   <= tail_pc;
        end
        if (push) begin
          if (count == 2'd2) begin
            tail_data <= imem_rdata;
            tail_pc   <= inflight_pc;
          end else begin
            head_data <= imem_rdata;
            head_pc   <= inflight_pc;
          end
        end
      end else if (push) begin
        if (count == 2'd0) begin
          head_data <= imem_rdata;
          head_pc   <= inflight_pc;
        end else begin
          tail_data <= imem_rdata;
          tail_pc   <= inflight_pc;
        end
      end
      count <= 2'(count + {1'b0, push} - {1'b0, pop});
    end
  end

  // The issue rule keeps occupancy at two, so a return can never find it full.
  assert property (@(posedge clock) disable iff (reset) !(push && (count == 2'd2)));

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters for accepted instructions and decode back-pressure.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop && (perf_fetched != '1)) perf_fetched <= perf_fetched + 1'b1;
      if ((state == RUN) && instr_valid && !instr_ready && (perf_stall != '1))
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule
